// File: rtl/count_logger_if.sv
// Sample/drain bus between a count_logger and its environment.
// The out_stamp signal exists only when COUNT_LOGGER_TIMESTAMP_EN is defined.
interface count_logger_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] count_in;
  logic             capture_en;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [LVL_W-1:0] level;
  logic             wrap_pulse;
  logic             overflow;
  logic             ovf_clr;
`ifdef COUNT_LOGGER_TIMESTAMP_EN
  logic [7:0]       out_stamp;
`endif

`ifdef COUNT_LOGGER_TIMESTAMP_EN
  modport master (
    output count_in, capture_en, out_ready, ovf_clr,
    input  out_data, out_valid, level, wrap_pulse, overflow, out_stamp
  );

  modport slave (
    input  count_in, capture_en, out_ready, ovf_clr,
    output out_data, out_valid, level, wrap_pulse, overflow, out_stamp
  );
`else
  modport master (
    output count_in, capture_en, out_ready, ovf_clr,
    input  out_data, out_valid, level, wrap_pulse, overflow
  );

  modport slave (
    input  count_in, capture_en, out_ready, ovf_clr,
    output out_data, out_valid, level, wrap_pulse, overflow
  );
`endif

endinterface

// File: rtl/count_logger.sv
// Watches a counter, queues every changed value in a first-word-fall-through FIFO,
// flags max->0 wraps and sticky drops. COUNT_LOGGER_TIMESTAMP_EN adds an 8-bit stamp per entry.
module count_logger #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  count_logger_if.slave  bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
`ifdef COUNT_LOGGER_TIMESTAMP_EN
  localparam int ENTRY_W = WIDTH + 8;
`else
  localparam int ENTRY_W = WIDTH;
`endif

  logic [WIDTH-1:0]   prev_q, prev_d;
  logic               prev_vld_q, prev_vld_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic               wrap_q, wrap_d;
`ifdef COUNT_LOGGER_TIMESTAMP_EN
  logic [7:0]         stamp_q, stamp_d;
`endif

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;

  logic [PTR_W-1:0]   level;
  logic               change;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic               wr_en;
  logic               drop;

  // Pointers carry one extra bit so full and empty differ without a separate count.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == PTR_W'(DEPTH));
  assign empty = (level == '0);

  always_comb begin
    change     = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    wr_en      = 1'b0;
    drop       = 1'b0;
    prev_d     = bus.count_in;
    prev_vld_d = 1'b1;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    wrap_d     = 1'b0;

    change = prev_vld_q && (bus.count_in != prev_q);
    push   = bus.capture_en && change;
    pop    = !empty && bus.out_ready;

    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    wr_en = push && (!full || pop);
    drop  = push && full && !pop;

    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end

    wrap_d = prev_vld_q && (prev_q == {WIDTH{1'b1}}) && (bus.count_in == '0);
  end

`ifdef COUNT_LOGGER_TIMESTAMP_EN
  assign stamp_d  = stamp_q + 8'd1;
  assign wr_entry = {stamp_q, bus.count_in};
`else
  assign wr_entry = bus.count_in;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      wrap_q     <= wrap_d;
    end
  end

`ifdef COUNT_LOGGER_TIMESTAMP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stamp_q <= '0;
    end else begin
      stamp_q <= stamp_d;
    end
  end
`endif

  // Storage is never reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end
  end

  assign head_entry = mem_q[rd_ptr_q[AW-1:0]];

  assign bus.out_data   = head_entry[WIDTH-1:0];
  assign bus.out_valid  = !empty;
  assign bus.level      = level;
  assign bus.wrap_pulse = wrap_q;
  assign bus.overflow   = overflow_q;
`ifdef COUNT_LOGGER_TIMESTAMP_EN
  assign bus.out_stamp  = head_entry[ENTRY_W-1 -: 8];
`endif

endmodule

// File: tb/tb_count_logger.sv
// Self-checking bench for count_logger: directed vector table, hand-written reset and
// stamp sequences, then random traffic against a queue-based reference model.
module tb_count_logger;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  count_logger_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  count_logger #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Reference model: a queue of pending values plus the last sample.
  int          m_q[$];
  logic [3:0]  m_prev;
  bit          m_vld;
  bit          m_ovf;
  bit          m_wrap;

  typedef struct {
    logic [3:0] cnt;
    bit         cap;
    bit         rdy;
    bit         clr;
    bit         e_valid;
    logic [3:0] e_data;
    int         e_level;
    bit         e_wrap;
    bit         e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int cnt, input int cap, input int rdy, input int clr,
                     input int ev, input int ed, input int el, input int ew, input int eo);
    vec_t v;
    v.cnt     = 4'(cnt);
    v.cap     = (cap != 0);
    v.rdy     = (rdy != 0);
    v.clr     = (clr != 0);
    v.e_valid = (ev != 0);
    v.e_data  = 4'(ed);
    v.e_level = el;
    v.e_wrap  = (ew != 0);
    v.e_ovf   = (eo != 0);
    tbl.push_back(v);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_prev = '0;
    m_vld  = 1'b0;
    m_ovf  = 1'b0;
    m_wrap = 1'b0;
  endtask

  task automatic model_update(input logic [3:0] c, input bit cap, input bit rdy, input bit clr);
    bit pop;
    bit push;
    bit drop;
    pop  = (m_q.size() != 0) && rdy;
    push = cap && m_vld && (c != m_prev);
    drop = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(int'(c));
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_wrap = m_vld && (m_prev == 4'hF) && (c == 4'h0);
    m_prev = c;
    m_vld  = 1'b1;
  endtask

  // One clock of traffic: drive on the falling edge, update the model at the rising
  // edge, compare 1 time unit later.
  task automatic step(input logic [3:0] c, input bit cap, input bit rdy, input bit clr);
    @(negedge clk);
    bus.count_in   = c;
    bus.capture_en = cap;
    bus.out_ready  = rdy;
    bus.ovf_clr    = clr;
    @(posedge clk);
    model_update(c, cap, rdy, clr);
    #1;
    n_txn++;
    $display("txn %0d: cnt=%0d cap=%0d rdy=%0d clr=%0d -> valid=%0d data=%0d level=%0d wrap=%0d ovf=%0d",
             n_txn, c, cap, rdy, clr, bus.out_valid, bus.out_data, bus.level,
             bus.wrap_pulse, bus.overflow);
    chk("model.valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
    chk("model.level", 32'(bus.level), 32'(m_q.size()));
    chk("model.wrap", 32'(bus.wrap_pulse), 32'(m_wrap));
    chk("model.ovf", 32'(bus.overflow), 32'(m_ovf));
    if (m_q.size() != 0) chk("model.data", 32'(bus.out_data), 32'(m_q[0]));
  endtask

  // Asynchronous reset asserted between clock edges, released before the next falling edge.
  task automatic mid_reset();
    #1;
    rst = 1'b0;
    #1;
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.level", 32'(bus.level), 32'd0);
    chk("rst.wrap", 32'(bus.wrap_pulse), 32'd0);
    chk("rst.ovf", 32'(bus.overflow), 32'd0);
    model_reset();
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [3:0] cnt;
    bit cap, rdy, clr;

    rst            = 1'b0;
    bus.count_in   = '0;
    bus.capture_en = 1'b1;
    bus.out_ready  = 1'b0;
    bus.ovf_clr    = 1'b0;
    model_reset();

    // Fields: cnt, cap, rdy, clr | valid, data, level, wrap, ovf after the edge.
    add( 0,1,1,0, 0, 0,0,0,0);  // baseline only
    add( 1,1,1,0, 1, 1,1,0,0);
    add( 2,1,1,0, 1, 2,1,0,0);
    add( 3,1,1,0, 1, 3,1,0,0);
    add( 0,0,1,0, 0, 0,0,0,0);  // drain, capture off
    add( 1,1,0,0, 1, 1,1,0,0);
    add( 2,1,0,0, 1, 1,2,0,0);
    add( 3,1,0,0, 1, 1,3,0,0);
    add( 4,1,0,0, 1, 1,4,0,0);
    add( 5,1,0,0, 1, 1,4,0,1);  // dropped
    add( 6,1,0,0, 1, 1,4,0,1);  // dropped
    add( 6,1,1,0, 1, 2,3,0,1);
    add( 6,1,1,0, 1, 3,2,0,1);
    add( 6,1,1,0, 1, 4,1,0,1);
    add( 6,1,1,0, 0, 0,0,0,1);
    add( 6,1,1,1, 0, 0,0,0,0);  // clear
    add(14,1,1,0, 1,14,1,0,0);
    add(15,1,1,0, 1,15,1,0,0);
    add( 0,1,1,0, 1, 0,1,1,0);  // wrap
    add( 1,1,1,0, 1, 1,1,0,0);
    add( 1,0,1,0, 0, 0,0,0,0);
    add(14,0,1,0, 0, 0,0,0,0);
    add(15,0,1,0, 0, 0,0,0,0);
    add( 0,0,1,0, 0, 0,0,1,0);  // wrap with capture off
    add( 1,0,1,0, 0, 0,0,0,0);
    add( 2,1,0,0, 1, 2,1,0,0);
    add( 3,1,0,0, 1, 2,2,0,0);
    add( 4,1,0,0, 1, 2,3,0,0);
    add( 5,1,0,0, 1, 2,4,0,0);
    add( 6,1,1,0, 1, 3,4,0,0);  // full, push+pop together
    add( 7,1,0,1, 1, 3,4,0,1);  // drop beats clear
    add( 7,1,1,0, 1, 4,3,0,1);
    add( 7,1,1,0, 1, 5,2,0,1);
    add( 7,1,1,0, 1, 6,1,0,1);
    add( 7,1,1,1, 0, 0,0,0,0);

    #12;
    chk("init.valid", 32'(bus.out_valid), 32'd0);
    chk("init.level", 32'(bus.level), 32'd0);
    chk("init.wrap", 32'(bus.wrap_pulse), 32'd0);
    chk("init.ovf", 32'(bus.overflow), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].cnt, tbl[i].cap, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("vec%0d.valid", i), 32'(bus.out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d.level", i), 32'(bus.level), 32'(tbl[i].e_level));
      chk($sformatf("vec%0d.wrap", i), 32'(bus.wrap_pulse), 32'(tbl[i].e_wrap));
      chk($sformatf("vec%0d.ovf", i), 32'(bus.overflow), 32'(tbl[i].e_ovf));
      if (tbl[i].e_valid) chk($sformatf("vec%0d.data", i), 32'(bus.out_data), 32'(tbl[i].e_data));
    end

    // Reset with three entries pending, then confirm the next sample is a baseline.
    step(4'd8, 1'b1, 1'b0, 1'b0);
    step(4'd9, 1'b1, 1'b0, 1'b0);
    step(4'd10, 1'b1, 1'b0, 1'b0);
    chk("pre_rst.level", 32'(bus.level), 32'd3);
    mid_reset();
    step(4'd10, 1'b1, 1'b0, 1'b0);
    chk("post_rst.baseline_level", 32'(bus.level), 32'd0);
    step(4'd11, 1'b1, 1'b0, 1'b0);
    chk("post_rst.level", 32'(bus.level), 32'd1);
    chk("post_rst.data", 32'(bus.out_data), 32'd11);
    step(4'd11, 1'b1, 1'b1, 1'b0);

`ifdef COUNT_LOGGER_TIMESTAMP_EN
    mid_reset();
    for (int k = 0; k <= 4; k++) step(4'(k), 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("stamp%0d", k), 32'(bus.out_stamp), 32'(k));
      step(4'd4, 1'b1, 1'b1, 1'b0);
    end
`endif

    // Random traffic: mostly unit steps so wraps happen, with occasional jumps and holds.
    cnt = bus.count_in;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0:       cnt = 4'($urandom_range(0, 15));
        1:       cnt = cnt;
        default: cnt = cnt + 4'd1;
      endcase
      cap = ($urandom_range(0, 4) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 9) == 0);
      step(cnt, cap, rdy, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
